bit_index_emitter: RTL and testbench

Multi-cycle inverse of the trailing/leading-zero counter in the crypto/bit-manipulation unit. It accepts a 32-bit word and streams the index of every set bit, one per handshake, either LSB-first or MSB-first. It sits beside the zero counter in the X-instruction execute path. It feeds sequential consumers such as bit-scatter/gather and iterated permutation steps.

---
 rtl/bit_index_emitter_pkg.sv | 9 +
 rtl/bit_index_emitter_finder.sv | 26 ++
 rtl/bit_index_emitter.sv | 70 +++++++
 tb/tb_bit_index_emitter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/bit_index_emitter_pkg.sv
// bit_index_emitter_pkg: shared widths, FSM state encoding and scan direction constants.
package bit_index_emitter_pkg;
  localparam int W = 32;
  localparam int IDXW = 5;
  localparam int CNTW = 6;
  localparam logic YON_LSB = 1'b0;
  localparam logic YON_MSB = 1'b1;
  typedef enum logic [1:0] {BOSTA = 2'd0, YAYIN = 2'd1, BITTI = 2'd2} state_t;
endpackage

// File: rtl/bit_index_emitter_finder.sv
// bit_position_finder: lowest (dir=0) or highest (dir=1) set-bit index plus any/single flags.
module bit_position_finder
  import bit_index_emitter_pkg::*;
#(
  parameter int PW = W,
  parameter int PIDXW = IDXW
) (
  input  logic [PW-1:0]    i_vec,
  input  logic             i_dir,
  output logic [PIDXW-1:0] o_idx,
  output logic             o_any,
  output logic             o_single
);
  logic [PW-1:0]    w_v;
  logic [PIDXW-1:0] w_pos;
  always_comb begin
    w_v = i_vec;
    if (i_dir == YON_MSB) for (int i = 0; i < PW; i++) w_v[i] = i_vec[PW-1-i];
    w_pos = '0;
    for (int i = PW-1; i >= 0; i--) if (w_v[i]) w_pos = PIDXW'(i);
    // a reversed-vector position p maps back to bit PW-1-p
    o_idx = i_dir == YON_MSB ? PIDXW'(PW-1) - w_pos : w_pos;
  end
  assign o_any = |i_vec;
  assign o_single = o_any && ((i_vec & (i_vec - PW'(1))) == '0);
endmodule

// File: rtl/bit_index_emitter.sv
// bit_index_emitter: streams the index of every set bit of a word, LSB- or MSB-first.
// Optional abort input iptal_i is present when BIT_INDEX_EMITTER_ABORT_EN is defined.
module bit_index_emitter
  import bit_index_emitter_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [W-1:0]    deger_i,
  input  logic            yon_i,
  output logic            hazir_o,
  output logic            idx_valid_o,
  output logic [IDXW-1:0] idx_o,
  input  logic            idx_ready_i,
  output logic            son_o,
  output logic            bitti_o,
`ifdef BIT_INDEX_EMITTER_ABORT_EN
  input  logic            iptal_i,
`endif
  output logic [CNTW-1:0] sayac_o
);
  state_t            r_state, w_next;
  logic [W-1:0]      r_res;
  logic              r_dir;
  logic [CNTW-1:0]   r_cnt;
  logic [IDXW-1:0]   w_idx;
  logic              w_any, w_single, w_xfer, w_abort;
  bit_position_finder #(.PW(W), .PIDXW(IDXW)) u_finder (
    .i_vec(r_res), .i_dir(r_dir), .o_idx(w_idx), .o_any(w_any), .o_single(w_single)
  );
`ifdef BIT_INDEX_EMITTER_ABORT_EN
  assign w_abort = iptal_i && r_state == YAYIN;
`else
  assign w_abort = 1'b0;
`endif
  assign hazir_o     = r_state == BOSTA;
  assign idx_valid_o = r_state == YAYIN && w_any;
  assign idx_o       = idx_valid_o ? w_idx : '0;
  assign son_o       = idx_valid_o && w_single;
  assign bitti_o     = r_state == BITTI;
  assign sayac_o     = r_cnt;
  assign w_xfer      = idx_valid_o && idx_ready_i;
  always_comb begin
    w_next = r_state;
    w_next = r_state == BOSTA ? (start_i ? (|deger_i ? YAYIN : BITTI) : BOSTA)
           : r_state == YAYIN ? (w_abort ? BOSTA : (w_xfer && w_single) ? BITTI : YAYIN)
           : BOSTA;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= BOSTA;
      r_res   <= '0;
      r_dir   <= YON_LSB;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (hazir_o && start_i) begin
        r_res <= deger_i;
        r_dir <= yon_i;
        r_cnt <= '0;
      end else if (r_state == YAYIN) begin
        if (w_xfer) begin
          r_res <= r_res & ~(W'(1) << w_idx);
          r_cnt <= r_cnt + CNTW'(1);
        end
        if (w_abort) r_res <= '0;
      end
    end
  end
endmodule

// File: tb/tb_bit_index_emitter.sv
// tb_bit_index_emitter: directed table-driven scans plus backpressure, reset and abort sequences.
module tb_bit_index_emitter;
  logic        clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0, yon_i = 1'b0, idx_ready_i = 1'b0;
  logic [31:0] deger_i = '0;
  logic        hazir_o, idx_valid_o, son_o, bitti_o;
  logic [4:0]  idx_o;
  logic [5:0]  sayac_o;
`ifdef BIT_INDEX_EMITTER_ABORT_EN
  logic        iptal_i = 1'b0;
`endif
  int n_checks = 0, n_fail = 0;
  bit_index_emitter dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .deger_i(deger_i), .yon_i(yon_i),
    .hazir_o(hazir_o), .idx_valid_o(idx_valid_o), .idx_o(idx_o), .idx_ready_i(idx_ready_i),
    .son_o(son_o), .bitti_o(bitti_o),
`ifdef BIT_INDEX_EMITTER_ABORT_EN
    .iptal_i(iptal_i),
`endif
    .sayac_o(sayac_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  typedef struct {
    logic [31:0] deger;
    logic        yon;
    int          cnt;
    int          first;
    int          last;
  } vec_t;
  vec_t tbl[6];
  task automatic start_scan(input logic [31:0] d, input logic y);
    deger_i = d; yon_i = y; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; deger_i = 32'hDEAD_BEEF; yon_i = ~y;
  endtask
  initial begin
    tbl[0] = '{32'h0000_0001, 1'b0, 1, 0, 0};
    tbl[1] = '{32'h8000_0011, 1'b0, 3, 0, 31};
    tbl[2] = '{32'h8000_0011, 1'b1, 3, 31, 0};
    tbl[3] = '{32'hFFFF_FFFF, 1'b1, 32, 31, 0};
    tbl[4] = '{32'hFFFF_FFFF, 1'b0, 32, 0, 31};
    tbl[5] = '{32'h0001_0000, 1'b1, 1, 16, 16};
    #2;
    check("rst_hazir", hazir_o, 1); check("rst_valid", idx_valid_o, 0);
    check("rst_idx", idx_o, 0); check("rst_son", son_o, 0);
    check("rst_bitti", bitti_o, 0); check("rst_sayac", sayac_o, 0);
    @(negedge clk_i); rst_i = 1'b0; idx_ready_i = 1'b1;
    @(negedge clk_i);
    foreach (tbl[t]) begin
      int exp_seq[$];
      exp_seq = {};
      for (int b = 0; b < 32; b++) if (tbl[t].deger[b]) exp_seq.push_back(b);
      if (tbl[t].yon) exp_seq.reverse();
      start_scan(tbl[t].deger, tbl[t].yon);
      check("tbl_first", idx_o, tbl[t].first);
      for (int k = 0; k < exp_seq.size(); k++) begin
        check("tbl_valid", idx_valid_o, 1);
        check("tbl_idx", idx_o, exp_seq[k]);
        check("tbl_son", son_o, k == exp_seq.size() - 1);
        if (k == exp_seq.size() - 1) check("tbl_last", idx_o, tbl[t].last);
        check("tbl_bitti_early", bitti_o, 0);
        @(negedge clk_i);
      end
      check("tbl_bitti", bitti_o, 1); check("tbl_valid_end", idx_valid_o, 0);
      check("tbl_hazir_end", hazir_o, 0); check("tbl_sayac", sayac_o, tbl[t].cnt);
      @(negedge clk_i);
      check("tbl_hazir_back", hazir_o, 1); check("tbl_bitti_off", bitti_o, 0);
      check("tbl_sayac_hold", sayac_o, tbl[t].cnt);
    end
    // zero word
    start_scan(32'h0, 1'b0);
    check("zero_valid", idx_valid_o, 0); check("zero_bitti", bitti_o, 1);
    check("zero_sayac", sayac_o, 0); check("zero_hazir", hazir_o, 0);
    @(negedge clk_i);
    check("zero_hazir_back", hazir_o, 1); check("zero_bitti_off", bitti_o, 0);
    // backpressure with an ignored mid-scan start
    idx_ready_i = 1'b0;
    start_scan(32'h0000_00A0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("bp_valid", idx_valid_o, 1); check("bp_idx", idx_o, 5); check("bp_son", son_o, 0);
      start_i = (k == 1); deger_i = 32'hFFFF_FFFF;
      if (k == 2) idx_ready_i = 1'b1;
      @(negedge clk_i);
    end
    start_i = 1'b0;
    check("bp_hazir", hazir_o, 0);
    check("bp_idx2", idx_o, 7); check("bp_son2", son_o, 1); check("bp_valid2", idx_valid_o, 1);
    @(negedge clk_i);
    check("bp_bitti", bitti_o, 1); check("bp_sayac", sayac_o, 2);
    @(negedge clk_i);
    check("bp_idle", hazir_o, 1); check("bp_novalid", idx_valid_o, 0);
    // asynchronous reset mid-scan
    start_scan(32'h0F00_0000, 1'b0);
    check("ar_idx0", idx_o, 24);
    @(negedge clk_i);
    check("ar_idx1", idx_o, 25); check("ar_sayac1", sayac_o, 1);
    #2 rst_i = 1'b1; #1;
    check("ar_hazir", hazir_o, 1); check("ar_valid", idx_valid_o, 0);
    check("ar_idx", idx_o, 0); check("ar_son", son_o, 0);
    check("ar_bitti", bitti_o, 0); check("ar_sayac", sayac_o, 0);
    @(negedge clk_i);
    check("ar_bitti_hold", bitti_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("ar_bitti_after", bitti_o, 0); check("ar_hazir_after", hazir_o, 1);
`ifdef BIT_INDEX_EMITTER_ABORT_EN
    start_scan(32'h8000_0011, 1'b0);
    check("ab_idx0", idx_o, 0);
    @(negedge clk_i);
    check("ab_idx1", idx_o, 4);
    iptal_i = 1'b1;
    @(negedge clk_i);
    iptal_i = 1'b0;
    check("ab_sayac", sayac_o, 2); check("ab_hazir", hazir_o, 1);
    check("ab_bitti", bitti_o, 0); check("ab_valid", idx_valid_o, 0);
    @(negedge clk_i);
    check("ab_bitti2", bitti_o, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
